// File: rtl/id_stage_hs_if.sv
// IF->ID->EX handshake bundle: instruction input side plus the registered ID/EX outputs.
// The stage connects through the slave modport; the surrounding pipeline uses master.
interface id_stage_hs_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5
);
   logic                  valid;
   logic                  ready;
   logic [31:0]           instruction;
   logic [DATA_W-1:0]     pc;

   logic                  ex_valid;
   logic                  ex_ready;
   logic [DATA_W-1:0]     ra;
   logic [DATA_W-1:0]     rb;
   logic [DATA_W-1:0]     imm;
   logic [REG_ADDR_W-1:0] rs;
   logic [REG_ADDR_W-1:0] rt;
   logic [REG_ADDR_W-1:0] rd;
   logic [5:0]            opcode;
   logic [5:0]            funct;
   logic [4:0]            shamt;
   logic [1:0]            ctl_wb;
   logic [4:0]            ctl_mem;
   logic [3:0]            ctl_ex;

   modport master (
      output valid, instruction, pc, ex_ready,
      input  ready, ex_valid, ra, rb, imm, rs, rt, rd, opcode, funct, shamt,
             ctl_wb, ctl_mem, ctl_ex
   );

   modport slave (
      input  valid, instruction, pc, ex_ready,
      output ready, ex_valid, ra, rb, imm, rs, rt, rd, opcode, funct, shamt,
             ctl_wb, ctl_mem, ctl_ex
   );
endinterface

// File: rtl/id_stage_hs.sv
// MIPS instruction decode stage with valid/ready handshake on both sides, a write-through
// register bank, optional ID-stage branch resolution and a RUN/HALT/END debug state machine.
module id_stage_hs #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned REG_ADDR_W   = 5,
   parameter bit          BRANCH_IN_ID = 1'b1,
   parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   id_stage_hs_if.slave          bus,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_halt,
   input  logic                  i_wb_we,
   input  logic [REG_ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0]     i_wb_data,
   output logic                  o_jump,
   output logic [DATA_W-1:0]     o_jump_address,
   output logic [REG_ADDR_W-1:0] o_rs_wire,
   output logic [REG_ADDR_W-1:0] o_rt_wire,
   input  logic [REG_ADDR_W-1:0] i_dbg_addr,
   output logic [DATA_W-1:0]     o_dbg_data,
   output logic                  o_program_end
);

   localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

   localparam logic [1:0] StRun  = 2'd0;
   localparam logic [1:0] StHalt = 2'd1;
   localparam logic [1:0] StEnd  = 2'd2;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnJalr  = 6'h09;

   logic [1:0]            state_q, state_d;
   logic [DATA_W-1:0]     bank_q [NumRegs];

   logic                  valid_q, prog_end_q;
   logic [DATA_W-1:0]     ra_q, rb_q, imm_q;
   logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;
   logic [5:0]            op_q, fn_q;
   logic [4:0]            sh_q;
   logic [1:0]            ctl_wb_q, ctl_wb_d;
   logic [4:0]            ctl_mem_q, ctl_mem_d;
   logic [3:0]            ctl_ex_q, ctl_ex_d;

   logic [31:0]           instr;
   logic [5:0]            f_op, f_fn;
   logic [REG_ADDR_W-1:0] f_rs, f_rt, f_rd;
   logic [DATA_W-1:0]     imm_ext;
   logic                  is_jr, is_jalr, is_jal, is_link, is_end;

   logic                  ready, take, wb_en, taken;
   logic [REG_ADDR_W-1:0] rd_a_addr;
   logic [DATA_W-1:0]     port_a, port_b, jump_target;

   assign instr   = bus.instruction;
   assign f_op    = instr[31:26];
   assign f_fn    = instr[5:0];
   assign f_rs    = REG_ADDR_W'(instr[25:21]);
   assign f_rt    = REG_ADDR_W'(instr[20:16]);
   assign f_rd    = REG_ADDR_W'(instr[15:11]);
   assign imm_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
   assign is_jr   = (f_op == OpRtype) && (f_fn == FnJr);
   assign is_jalr = (f_op == OpRtype) && (f_fn == FnJalr);
   assign is_jal  = (f_op == OpJal);
   assign is_link = is_jal || is_jalr;
   assign is_end  = (instr == END_WORD);

   assign o_rs_wire = f_rs;
   assign o_rt_wire = f_rt;

   assign ready = (state_q == StRun) && !i_halt && !i_stall && (!valid_q || bus.ex_ready);
   assign take  = bus.valid && ready && !i_flush;
   assign bus.ready = ready;

   // Bank writes are frozen while halted; an active write forwards straight to the reads.
   assign wb_en     = i_wb_we && (state_q != StHalt) && !i_halt && (i_wb_addr != '0);
   assign rd_a_addr = (i_halt || state_q == StEnd) ? i_dbg_addr : f_rs;
   assign port_a    = (wb_en && i_wb_addr == rd_a_addr) ? i_wb_data : bank_q[rd_a_addr];
   assign port_b    = (wb_en && i_wb_addr == f_rt) ? i_wb_data : bank_q[f_rt];
   assign o_dbg_data = port_a;

   always_comb begin
      ctl_wb_d  = '0;
      ctl_mem_d = '0;
      ctl_ex_d  = '0;
      if (instr != '0 && !is_end) begin
         if (f_op == OpRtype) begin
            ctl_wb_d = is_jr ? 2'b10 : 2'b11;
            ctl_ex_d = is_jalr ? 4'b1000 : 4'b1100;
         end else if (f_op[5:3] == 3'b100 || f_op[5:3] == 3'b101) begin
            ctl_wb_d  = f_op[3] ? 2'b10 : 2'b01;
            ctl_mem_d = {~f_op[3], f_op[3], f_op[2], f_op[1:0]};
            ctl_ex_d  = 4'b0001;
         end else if (f_op[5:3] == 3'b001) begin
            ctl_wb_d = 2'b11;
            ctl_ex_d = 4'b0111;
         end else if (f_op == OpBeq || f_op == OpBne) begin
            ctl_wb_d = 2'b10;
            ctl_ex_d = 4'b0010;
         end else if (is_jal) begin
            ctl_wb_d = 2'b11;
            ctl_ex_d = 4'b1000;
         end else if (f_op == OpJ) begin
            ctl_wb_d = 2'b10;
         end
      end
   end

   always_comb begin
      taken       = 1'b0;
      jump_target = bus.pc + (imm_ext << 2);
      if (f_op == OpBeq) begin
         taken = (port_a == port_b);
      end else if (f_op == OpBne) begin
         taken = (port_a != port_b);
      end else if (f_op == OpJ || f_op == OpJal) begin
         taken       = 1'b1;
         jump_target = {bus.pc[DATA_W-1:28], instr[25:0], 2'b00};
      end else if (is_jr || is_jalr) begin
         taken       = 1'b1;
         jump_target = port_a;
      end
   end

   assign o_jump         = BRANCH_IN_ID && bus.valid && ready && !i_flush && taken;
   assign o_jump_address = jump_target;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:   if (i_halt) state_d = StHalt;
                  else if (take && is_end) state_d = StEnd;
         StHalt:  if (!i_halt) state_d = StRun;
         StEnd:   state_d = StEnd;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= StRun;
         prog_end_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take && is_end) prog_end_q <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < NumRegs; i++) bank_q[i] <= '0;
      end else if (wb_en) begin
         bank_q[i_wb_addr] <= i_wb_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q   <= 1'b0;
         ra_q      <= '0;
         rb_q      <= '0;
         imm_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         op_q      <= '0;
         fn_q      <= '0;
         sh_q      <= '0;
         ctl_wb_q  <= '0;
         ctl_mem_q <= '0;
         ctl_ex_q  <= '0;
      end else if (i_flush) begin
         valid_q   <= 1'b0;
         ctl_wb_q  <= '0;
         ctl_mem_q <= '0;
         ctl_ex_q  <= '0;
      end else if (state_q == StHalt || i_halt) begin
         valid_q <= valid_q;
      end else if (take) begin
         valid_q   <= 1'b1;
         ra_q      <= is_link ? bus.pc : port_a;
         rb_q      <= is_link ? DATA_W'(4) : port_b;
         imm_q     <= imm_ext;
         rs_q      <= f_rs;
         rt_q      <= is_link ? '0 : f_rt;
         rd_q      <= is_jal ? '1 : f_rd;
         op_q      <= f_op;
         fn_q      <= f_fn;
         sh_q      <= instr[10:6];
         ctl_wb_q  <= ctl_wb_d;
         ctl_mem_q <= ctl_mem_d;
         ctl_ex_q  <= ctl_ex_d;
      end else if (!valid_q || bus.ex_ready) begin
         // Bubble: data fields keep their last value, only validity and control clear.
         valid_q   <= 1'b0;
         ctl_wb_q  <= '0;
         ctl_mem_q <= '0;
         ctl_ex_q  <= '0;
      end
   end

   assign bus.ex_valid   = valid_q;
   assign bus.ra         = ra_q;
   assign bus.rb         = rb_q;
   assign bus.imm        = imm_q;
   assign bus.rs         = rs_q;
   assign bus.rt         = rt_q;
   assign bus.rd         = rd_q;
   assign bus.opcode     = op_q;
   assign bus.funct      = fn_q;
   assign bus.shamt      = sh_q;
   assign bus.ctl_wb     = ctl_wb_q;
   assign bus.ctl_mem    = ctl_mem_q;
   assign bus.ctl_ex     = ctl_ex_q;
   assign o_program_end  = prog_end_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: directed scenarios plus a randomized stream scored against a
// behavioural model of decode, register file, branch targets and the handshake.
module tb_id_stage_hs;

   typedef struct packed {
      logic [31:0] ra, rb, imm;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  op, fn;
      logic [4:0]  sh;
      logic [1:0]  wb;
      logic [4:0]  mem;
      logic [3:0]  ex;
   } bundle_t;

   logic        clk, rst;
   logic        stall, flush, halt, wb_we;
   logic [4:0]  wb_addr, dbg_addr, rs_wire, rt_wire;
   logic [31:0] wb_data, jump_addr, dbg_data;
   logic        jump, program_end;
   logic [31:0] mregs [32];
   int          checks, failures;

   id_stage_hs_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

   id_stage_hs #(.DATA_W(32), .REG_ADDR_W(5), .BRANCH_IN_ID(1'b1),
                 .END_WORD(32'hFFFF_FFFF)) dut (
      .i_clk(clk), .i_reset(rst), .bus(bus), .i_stall(stall), .i_flush(flush),
      .i_halt(halt), .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .o_jump(jump), .o_jump_address(jump_addr), .o_rs_wire(rs_wire), .o_rt_wire(rt_wire),
      .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data), .o_program_end(program_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.valid = 1'b0; bus.instruction = 32'h0; bus.pc = 32'h0; bus.ex_ready = 1'b1;
      stall = 1'b0; flush = 1'b0; halt = 1'b0; wb_we = 1'b0; wb_addr = 5'd0;
      wb_data = 32'h0; dbg_addr = 5'd0;
   endtask

   // Register read as EX would see it this cycle, including a concurrent WB write.
   function automatic logic [31:0] rd_model(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wb_we && wb_addr == a) return wb_data;
      return mregs[a];
   endfunction

   function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
      bundle_t b;
      logic [5:0] op;
      logic link;
      op = ins[31:26];
      b.op = op; b.fn = ins[5:0]; b.sh = ins[10:6];
      b.rs = ins[25:21]; b.rt = ins[20:16]; b.rd = ins[15:11];
      b.imm = {{16{ins[15]}}, ins[15:0]};
      b.ra = rd_model(b.rs); b.rb = rd_model(b.rt);
      b.wb = 2'b00; b.mem = 5'b0; b.ex = 4'b0;
      link = (op == 6'h03) || (op == 6'h00 && b.fn == 6'h09);
      if (link) begin b.ra = pc; b.rb = 32'd4; b.rt = 5'd0; end
      if (op == 6'h03) b.rd = 5'd31;
      if (ins != 32'h0 && ins != 32'hFFFF_FFFF) begin
         if (op == 6'h00) begin
            b.wb = (b.fn == 6'h08) ? 2'b10 : 2'b11;
            b.ex = {1'b1, (b.fn == 6'h09) ? 2'b00 : 2'b10, 1'b0};
         end else if (op >= 6'h20 && op < 6'h28) begin
            b.wb = 2'b01; b.mem = {1'b1, 1'b0, op[2], op[1:0]}; b.ex = 4'b0001;
         end else if (op >= 6'h28 && op < 6'h30) begin
            b.wb = 2'b10; b.mem = {1'b0, 1'b1, op[2], op[1:0]}; b.ex = 4'b0001;
         end else if (op >= 6'h08 && op < 6'h10) begin
            b.wb = 2'b11; b.ex = 4'b0111;
         end else if (op == 6'h04 || op == 6'h05) begin
            b.wb = 2'b10; b.ex = 4'b0010;
         end else if (op == 6'h03) begin
            b.wb = 2'b11; b.ex = 4'b1000;
         end else if (op == 6'h02) begin
            b.wb = 2'b10;
         end
      end
      return b;
   endfunction

   function automatic logic [32:0] model_jump(input logic [31:0] ins, input logic [31:0] pc);
      logic [5:0]  op;
      logic [31:0] a, b, off;
      op  = ins[31:26];
      a   = rd_model(ins[25:21]);
      b   = rd_model(ins[20:16]);
      off = {{14{ins[15]}}, ins[15:0], 2'b00};
      if (op == 6'h04) return {a == b, pc + off};
      if (op == 6'h05) return {a != b, pc + off};
      if (op == 6'h02 || op == 6'h03) return {1'b1, pc[31:28], ins[25:0], 2'b00};
      if (op == 6'h00 && (ins[5:0] == 6'h08 || ins[5:0] == 6'h09)) return {1'b1, a};
      return 33'h0;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [4:0]  s, t, d;
      logic [15:0] im;
      s  = 5'($urandom_range(0, 7));
      t  = 5'($urandom_range(0, 7));
      d  = 5'($urandom_range(0, 7));
      im = 16'($urandom);
      case ($urandom_range(0, 11))
         0:  return {6'h00, s, t, d, 5'd0, 6'h20};
         1:  return {6'h08, s, t, im};
         2:  return {6'h23, s, t, im};
         3:  return {6'h24, s, t, im};
         4:  return {6'h2B, s, t, im};
         5:  return {6'h04, s, t, im};
         6:  return {6'h05, s, t, im};
         7:  return {6'h02, 26'($urandom)};
         8:  return {6'h03, 26'($urandom)};
         9:  return {6'h00, s, 5'd0, 5'd0, 5'd0, 6'h08};
         10: return {6'h00, s, 5'd0, d, 5'd0, 6'h09};
         default: return 32'h0;
      endcase
   endfunction

   task automatic test_reset();
      #1;
      checks++;
      if ({bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex} !== 12'h0) begin
         failures++;
         $display("FAIL reset_ctl got=%h exp=0",
                  {bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex});
      end
      checks++;
      if ({program_end, bus.ra, bus.imm} !== 65'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {program_end, bus.ra, bus.imm});
      end
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready);
      end
      halt = 1'b1; dbg_addr = 5'd7;
      #1;
      checks++;
      if (dbg_data !== 32'h0) begin
         failures++; $display("FAIL reset_bank got=%h exp=0", dbg_data);
      end
      halt = 1'b0;
   endtask

   task automatic test_addi();
      idle();
      bus.valid = 1'b1; bus.instruction = 32'h2001_0005; bus.pc = 32'h100;
      tick();
      bus.valid = 1'b0;
      checks++;
      if ({bus.ex_valid, bus.imm, bus.rt, bus.rs, bus.opcode} !== {1'b1, 32'd5, 5'd1, 5'd0, 6'h08})
      begin
         failures++;
         $display("FAIL addi_fields got=%h exp=%h", {bus.ex_valid, bus.imm, bus.rt, bus.rs,
                  bus.opcode}, {1'b1, 32'd5, 5'd1, 5'd0, 6'h08});
      end
      checks++;
      if ({bus.ctl_wb, bus.ctl_mem, bus.ctl_ex} !== {2'b11, 5'b0, 4'b0111}) begin
         failures++;
         $display("FAIL addi_ctl got=%b exp=%b", {bus.ctl_wb, bus.ctl_mem, bus.ctl_ex},
                  {2'b11, 5'b0, 4'b0111});
      end
      tick();
      checks++;
      if ({bus.ex_valid, bus.ctl_wb, bus.ctl_ex} !== 7'h0) begin
         failures++;
         $display("FAIL addi_bubble got=%b exp=0", {bus.ex_valid, bus.ctl_wb, bus.ctl_ex});
      end
   endtask

   task automatic test_bypass_branch();
      idle();
      bus.valid = 1'b1; bus.instruction = 32'h1063_0004; bus.pc = 32'h200;
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
      #1;
      checks++;
      if ({jump, jump_addr} !== {1'b1, 32'h210}) begin
         failures++; $display("FAIL beq_jump got=%h exp=%h", {jump, jump_addr}, {1'b1, 32'h210});
      end
      checks++;
      if ({rs_wire, rt_wire} !== {5'd3, 5'd3}) begin
         failures++; $display("FAIL beq_wires got=%h exp=%h", {rs_wire, rt_wire}, 10'h063);
      end
      tick();
      mregs[3] = 32'hAA;
      wb_we = 1'b0;
      bus.instruction = 32'h1463_0004; bus.pc = 32'h300;
      checks++;
      if ({bus.ra, bus.rb, bus.ctl_wb, bus.ctl_ex} !== {32'hAA, 32'hAA, 2'b10, 4'b0010}) begin
         failures++;
         $display("FAIL beq_bundle got=%h exp=%h", {bus.ra, bus.rb, bus.ctl_wb, bus.ctl_ex},
                  {32'hAA, 32'hAA, 2'b10, 4'b0010});
      end
      #1;
      checks++;
      if (jump !== 1'b0) begin
         failures++; $display("FAIL bne_not_taken got=%b exp=0", jump);
      end
      tick();
      bus.valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      idle();
      bus.valid = 1'b1; bus.instruction = 32'h2002_0007;
      tick();
      bus.instruction = 32'h2004_0009; bus.ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", i, bus.ready);
         end
         tick();
         checks++;
         if ({bus.ex_valid, bus.imm, bus.rt} !== {1'b1, 32'd7, 5'd2}) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got=%h exp=%h", i,
                     {bus.ex_valid, bus.imm, bus.rt}, {1'b1, 32'd7, 5'd2});
         end
      end
      bus.ex_ready = 1'b1;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++; $display("FAIL bp_release got=%b exp=1", bus.ready);
      end
      tick();
      bus.valid = 1'b0;
      checks++;
      if ({bus.ex_valid, bus.imm, bus.rt} !== {1'b1, 32'd9, 5'd4}) begin
         failures++;
         $display("FAIL bp_next got=%h exp=%h", {bus.ex_valid, bus.imm, bus.rt},
                  {1'b1, 32'd9, 5'd4});
      end
      tick();
   endtask

   task automatic test_flush();
      idle();
      bus.valid = 1'b1; bus.instruction = 32'h2002_0007;
      tick();
      bus.instruction = 32'h8C05_0008; flush = 1'b1; bus.ex_ready = 1'b0;
      tick();
      checks++;
      if ({bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex} !== 12'h0) begin
         failures++;
         $display("FAIL flush_clear got=%h exp=0",
                  {bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex});
      end
      bus.instruction = 32'h1000_0001;
      #1;
      checks++;
      if (jump !== 1'b0) begin
         failures++; $display("FAIL flush_jump got=%b exp=0", jump);
      end
      tick();
      flush = 1'b0; bus.ex_ready = 1'b1; bus.instruction = 32'h8C05_0008;
      tick();
      bus.valid = 1'b0;
      checks++;
      if ({bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex, bus.imm, bus.rt} !==
          {1'b1, 2'b01, 5'b10011, 4'b0001, 32'd8, 5'd5}) begin
         failures++;
         $display("FAIL flush_lw got=%h exp=%h",
                  {bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex, bus.imm, bus.rt},
                  {1'b1, 2'b01, 5'b10011, 4'b0001, 32'd8, 5'd5});
      end
      bus.valid = 1'b1; bus.instruction = 32'hFFFF_FFFF; flush = 1'b1;
      tick();
      flush = 1'b0; bus.valid = 1'b0;
      #1;
      checks++;
      if ({program_end, bus.ex_valid, bus.ready} !== 3'b001) begin
         failures++;
         $display("FAIL flush_end got=%b exp=001", {program_end, bus.ex_valid, bus.ready});
      end
   endtask

   task automatic test_halt();
      idle();
      bus.valid = 1'b1; bus.instruction = 32'h2002_0007;
      tick();
      bus.valid = 1'b0; halt = 1'b1; dbg_addr = 5'd3;
      wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
      #1;
      checks++;
      if ({bus.ready, dbg_data} !== {1'b0, 32'hAA}) begin
         failures++;
         $display("FAIL halt_dbg got=%h exp=%h", {bus.ready, dbg_data}, {1'b0, 32'hAA});
      end
      tick();
      tick();
      checks++;
      if ({bus.ex_valid, bus.imm, bus.ctl_wb} !== {1'b1, 32'd7, 2'b11}) begin
         failures++;
         $display("FAIL halt_hold got=%h exp=%h", {bus.ex_valid, bus.imm, bus.ctl_wb},
                  {1'b1, 32'd7, 2'b11});
      end
      wb_we = 1'b0; dbg_addr = 5'd6;
      #1;
      checks++;
      if (dbg_data !== 32'h0) begin
         failures++; $display("FAIL halt_wb_blocked got=%h exp=0", dbg_data);
      end
      halt = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic test_random();
      bundle_t     exp_b, nb;
      logic        exp_valid, exp_ready, acc, exp_jump;
      logic [32:0] jm;
      idle();
      tick();
      exp_valid = 1'b0;
      exp_b = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.valid       = ($urandom_range(0, 3) != 0);
         bus.instruction = gen_instr();
         bus.pc          = $urandom & 32'hFFFF_FFFC;
         bus.ex_ready    = ($urandom_range(0, 2) != 0);
         stall           = ($urandom_range(0, 5) == 0);
         wb_we           = $urandom_range(0, 1) == 1;
         wb_addr         = 5'($urandom_range(0, 7));
         wb_data         = $urandom;
         #1;
         exp_ready = !stall && (!exp_valid || bus.ex_ready);
         acc       = bus.valid && exp_ready;
         jm        = model_jump(bus.instruction, bus.pc);
         exp_jump  = acc && jm[32];
         checks++;
         if (bus.ready !== exp_ready) begin
            failures++;
            $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.ready, exp_ready);
         end
         checks++;
         if (jump !== exp_jump || (exp_jump && jump_addr !== jm[31:0])) begin
            failures++;
            $display("FAIL rnd_jump cyc=%0d got=%b/%h exp=%b/%h", cyc, jump, jump_addr,
                     exp_jump, jm[31:0]);
         end
         nb = model_decode(bus.instruction, bus.pc);
         tick();
         if (wb_we && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
         if (acc) begin
            exp_b = nb; exp_valid = 1'b1;
         end else if (bus.ex_ready || !exp_valid) begin
            exp_valid = 1'b0; exp_b.wb = 2'b0; exp_b.mem = 5'b0; exp_b.ex = 4'b0;
         end
         checks++;
         if ({bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex} !==
             {exp_valid, exp_b.wb, exp_b.mem, exp_b.ex}) begin
            failures++;
            $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc,
                     {bus.ex_valid, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex},
                     {exp_valid, exp_b.wb, exp_b.mem, exp_b.ex});
         end
         if (exp_valid) begin
            checks++;
            if ({bus.ra, bus.rb, bus.imm, bus.rs, bus.rt, bus.rd, bus.opcode, bus.funct,
                 bus.shamt} !== {exp_b.ra, exp_b.rb, exp_b.imm, exp_b.rs, exp_b.rt, exp_b.rd,
                 exp_b.op, exp_b.fn, exp_b.sh}) begin
               failures++;
               $display("FAIL rnd_data cyc=%0d got=%h/%h/%h/%h/%h/%h exp=%h/%h/%h/%h/%h/%h",
                        cyc, bus.ra, bus.rb, bus.imm, bus.rs, bus.rt, bus.rd,
                        exp_b.ra, exp_b.rb, exp_b.imm, exp_b.rs, exp_b.rt, exp_b.rd);
            end
         end
      end
      idle();
      tick();
   endtask

   task automatic test_end_debug();
      idle();
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
      tick();
      mregs[3] = 32'hAA;
      wb_we = 1'b0;
      bus.valid = 1'b1; bus.instruction = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++; $display("FAIL end_accept_ready got=%b exp=1", bus.ready);
      end
      tick();
      bus.instruction = 32'h2001_0005;
      checks++;
      if ({program_end, bus.ex_valid, bus.opcode, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex} !==
          {1'b1, 1'b1, 6'h3F, 11'h0}) begin
         failures++;
         $display("FAIL end_bundle got=%h exp=%h",
                  {program_end, bus.ex_valid, bus.opcode, bus.ctl_wb, bus.ctl_mem, bus.ctl_ex},
                  {1'b1, 1'b1, 6'h3F, 11'h0});
      end
      #1;
      checks++;
      if (bus.ready !== 1'b0) begin
         failures++; $display("FAIL end_ready got=%b exp=0", bus.ready);
      end
      tick();
      dbg_addr = 5'd3;
      #1;
      checks++;
      if ({program_end, bus.ex_valid, dbg_data} !== {1'b1, 1'b0, 32'hAA}) begin
         failures++;
         $display("FAIL end_dbg got=%h exp=%h", {program_end, bus.ex_valid, dbg_data},
                  {1'b1, 1'b0, 32'hAA});
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      checks++;
      if ({program_end, bus.ready} !== 2'b10) begin
         failures++; $display("FAIL end_sticky got=%b exp=10", {program_end, bus.ready});
      end
   endtask

   task automatic test_async_reset();
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({program_end, bus.ex_valid, bus.imm, bus.opcode} !== 40'h0) begin
         failures++;
         $display("FAIL areset_outputs got=%h exp=0",
                  {program_end, bus.ex_valid, bus.imm, bus.opcode});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      idle();
      halt = 1'b1; dbg_addr = 5'd3;
      #1;
      checks++;
      if (dbg_data !== 32'h0) begin
         failures++; $display("FAIL areset_bank got=%h exp=0", dbg_data);
      end
      halt = 1'b0;
      #1;
      checks++;
      if (bus.ready !== 1'b1) begin
         failures++; $display("FAIL areset_run got=%b exp=1", bus.ready);
      end
      bus.valid = 1'b1; bus.instruction = 32'h2001_0005;
      tick();
      bus.valid = 1'b0;
      checks++;
      if ({bus.ex_valid, bus.imm} !== {1'b1, 32'd5}) begin
         failures++;
         $display("FAIL areset_resume got=%h exp=%h", {bus.ex_valid, bus.imm}, {1'b1, 32'd5});
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      test_reset();
      test_addi();
      test_bypass_branch();
      test_backpressure();
      test_flush();
      test_halt();
      test_random();
      test_end_debug();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
